// File: rtl/split_port_ram_p.sv
// Shared RAM that two independent single-port interfaces access through one dual-port array.
// Optional feature: define SPLIT_RAM_FWD_EN to forward cross-port write data to a same-address reader.
module split_port_ram_p #(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          ADDR_W   = 4,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0,
    parameter int unsigned          PRIO     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_0,
    input  logic              rd_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic [DATA_W-1:0] rdata_0,
    output logic              rvalid_0,
    output logic              err_0,
    input  logic              wr_1,
    input  logic              rd_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic              rvalid_1,
    output logic              err_1,
    output logic              ready,
    output logic              collision
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {StInit, StRun} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              rd_ok_0, rd_ok_1, wr_ok_0, wr_ok_1;
    logic              coll, we_0, we_1;
    logic [DATA_W-1:0] rd_word_0, rd_word_1;

    assign run     = (state == StRun);
    assign rd_ok_0 = run & rd_0 & ~wr_0;
    assign rd_ok_1 = run & rd_1 & ~wr_1;
    assign wr_ok_0 = run & wr_0 & ~rd_0;
    assign wr_ok_1 = run & wr_1 & ~rd_1;
    assign coll    = wr_ok_0 & wr_ok_1 & (addr_0 == addr_1);

    // On a same-address collision only the priority port's write reaches the array.
    assign we_0 = wr_ok_0 & ~(coll & (PRIO != 0));
    assign we_1 = wr_ok_1 & ~(coll & (PRIO == 0));

`ifdef SPLIT_RAM_FWD_EN
    assign rd_word_0 = (we_1 && addr_1 == addr_0) ? wdata_1 : mem[addr_0];
    assign rd_word_1 = (we_0 && addr_0 == addr_1) ? wdata_0 : mem[addr_1];
`else
    assign rd_word_0 = mem[addr_0];
    assign rd_word_1 = mem[addr_1];
`endif

    // Array has no reset; the sweep clears it after each reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == StInit) begin
                mem[cnt] <= INIT_VAL;
            end else begin
                if (we_0) mem[addr_0] <= wdata_0;
                if (we_1) mem[addr_1] <= wdata_1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StInit;
            cnt       <= '0;
            ready     <= 1'b0;
            rdata_0   <= '0;
            rdata_1   <= '0;
            rvalid_0  <= 1'b0;
            rvalid_1  <= 1'b0;
            err_0     <= 1'b0;
            err_1     <= 1'b0;
            collision <= 1'b0;
        end else begin
            case (state)
                StInit: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= StRun;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= StRun;
                end
            endcase
            rvalid_0  <= rd_ok_0;
            rvalid_1  <= rd_ok_1;
            if (rd_ok_0) rdata_0 <= rd_word_0;
            if (rd_ok_1) rdata_1 <= rd_word_1;
            // Any request while sweeping is illegal; in RUN only rd+wr together is.
            err_0     <= run ? (rd_0 & wr_0) : (rd_0 | wr_0);
            err_1     <= run ? (rd_1 & wr_1) : (rd_1 | wr_1);
            collision <= coll;
        end
    end
endmodule

// File: tb/tb_split_port_ram_p.sv
// Scoreboard bench for split_port_ram_p; a second instance with PRIO=1 covers collision priority.
module tb_split_port_ram_p;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_0 = 0, rd_0 = 0, wr_1 = 0, rd_1 = 0;
    logic [3:0] addr_0 = 0, addr_1 = 0;
    logic [7:0] wdata_0 = 0, wdata_1 = 0;
    logic [7:0] rdata_0, rdata_1, p1_rdata_0, p1_rdata_1;
    logic       rvalid_0, rvalid_1, err_0, err_1, ready, collision;
    logic       p1_rvalid_0, p1_rvalid_1, p1_err_0, p1_err_1, p1_ready, p1_collision;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] fwd_exp;

    always #5 clk = ~clk;

    split_port_ram_p #(.DATA_W(8), .ADDR_W(4), .INIT_VAL(8'h00), .PRIO(0)) u_dut (
        .clk(clk), .rst(rst),
        .wr_0(wr_0), .rd_0(rd_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .rdata_0(rdata_0), .rvalid_0(rvalid_0), .err_0(err_0),
        .wr_1(wr_1), .rd_1(rd_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .rdata_1(rdata_1), .rvalid_1(rvalid_1), .err_1(err_1),
        .ready(ready), .collision(collision)
    );

    split_port_ram_p #(.DATA_W(8), .ADDR_W(4), .INIT_VAL(8'h00), .PRIO(1)) u_dut_p1 (
        .clk(clk), .rst(rst),
        .wr_0(wr_0), .rd_0(rd_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .rdata_0(p1_rdata_0), .rvalid_0(p1_rvalid_0), .err_0(p1_err_0),
        .wr_1(wr_1), .rd_1(rd_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .rdata_1(p1_rdata_1), .rvalid_1(p1_rvalid_1), .err_1(p1_err_1),
        .ready(p1_ready), .collision(p1_collision)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_0 = 0; rd_0 = 0; wr_1 = 0; rd_1 = 0;
    endtask

    // Pop one expected word per rvalid pulse.
    always @(posedge clk) begin
        #1;
        if (rvalid_0) begin
            if (q0.size() == 0) chk("p0_unexpected_rvalid", 1, 0);
            else chk("p0_rdata", rdata_0, q0.pop_front());
        end
        if (rvalid_1) begin
            if (q1.size() == 0) chk("p1_unexpected_rvalid", 1, 0);
            else chk("p1_rdata", rdata_1, q1.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset state, then clear sweep with rd_0 held high
        rd_0 = 1;
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_err0", err_0, 0);
        chk("rst_rvalid0", rvalid_0, 0);
        chk("rst_rdata0", rdata_0, 0);
        chk("rst_collision", collision, 0);
        rst = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("sweep_ready", ready, (k == 16));
            chk("sweep_err0", err_0, 1);
        end
        rd_0 = 0;
        for (int a = 0; a < 16; a++) begin
            rd_0 = 1; addr_0 = 4'(a); q0.push_back(8'h00);
            tick();
        end
        idle();
        tick();
        chk("post_sweep_err0", err_0, 0);

        // 2. Basic write then read from the other port
        wr_0 = 1; addr_0 = 4'd3; wdata_0 = 8'hA5;
        tick();
        idle();
        rd_1 = 1; addr_1 = 4'd3; q1.push_back(8'hA5);
        tick();
        chk("basic_rvalid1", rvalid_1, 1);
        idle();
        tick();
        chk("basic_rvalid1_drop", rvalid_1, 0);
        chk("basic_rdata1_hold", rdata_1, 8'hA5);

        // 3. Same-address write collision
        wr_0 = 1; addr_0 = 4'd7; wdata_0 = 8'h11;
        wr_1 = 1; addr_1 = 4'd7; wdata_1 = 8'h22;
        tick();
        chk("coll_pulse", collision, 1);
        chk("coll_p1_pulse", p1_collision, 1);
        chk("coll_err0", err_0, 0);
        chk("coll_err1", err_1, 0);
        idle();
        rd_0 = 1; addr_0 = 4'd7; q0.push_back(8'h11);
        tick();
        chk("coll_clear", collision, 0);
        chk("coll_prio1_data", p1_rdata_0, 8'h22);
        idle();
        // different addresses: both writes land
        wr_0 = 1; addr_0 = 4'd8; wdata_0 = 8'h81;
        wr_1 = 1; addr_1 = 4'd9; wdata_1 = 8'h92;
        tick();
        chk("diff_no_coll", collision, 0);
        idle();
        rd_0 = 1; addr_0 = 4'd8; q0.push_back(8'h81);
        rd_1 = 1; addr_1 = 4'd9; q1.push_back(8'h92);
        tick();
        rd_0 = 1; addr_0 = 4'd9; q0.push_back(8'h92);
        rd_1 = 1; addr_1 = 4'd9; q1.push_back(8'h92);
        tick();
        chk("dual_read_no_coll", collision, 0);
        idle();

        // 4. Cross-port read during write
        wr_0 = 1; addr_0 = 4'd5; wdata_0 = 8'h33;
        tick();
`ifdef SPLIT_RAM_FWD_EN
        fwd_exp = 8'h44;
`else
        fwd_exp = 8'h33;
`endif
        wr_0 = 1; addr_0 = 4'd5; wdata_0 = 8'h44;
        rd_1 = 1; addr_1 = 4'd5; q1.push_back(fwd_exp);
        tick();
        idle();
        rd_0 = 1; addr_0 = 4'd5; q0.push_back(8'h44);
        tick();
        idle();

        // 5. Illegal rd+wr on one port
        wr_1 = 1; addr_1 = 4'd2; wdata_1 = 8'h5A;
        tick();
        idle();
        rd_0 = 1; wr_0 = 1; addr_0 = 4'd2; wdata_0 = 8'hFF;
        tick();
        chk("illegal_err0", err_0, 1);
        chk("illegal_rvalid0", rvalid_0, 0);
        idle();
        rd_0 = 1; addr_0 = 4'd2; q0.push_back(8'h5A);
        tick();
        chk("illegal_err0_drop", err_0, 0);

        // 6. Reset mid-read and mid-sweep
        chk("pre_rst_rvalid0", rvalid_0, 1);
        #2;
        rst = 1;
        #1;
        chk("async_rst_rvalid0", rvalid_0, 0);
        chk("async_rst_rdata0", rdata_0, 0);
        chk("async_rst_ready", ready, 0);
        idle();
        tick();
        rst = 0;
        wr_1 = 1;
        for (int k = 0; k < 6; k++) tick();
        chk("mid_sweep_err1", err_1, 1);
        chk("mid_sweep_ready", ready, 0);
        #2;
        rst = 1;
        #1;
        chk("async_rst_err1", err_1, 0);
        idle();
        tick();
        rst = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("resweep_ready", ready, (k == 16));
        end
        rd_0 = 1; addr_0 = 4'd3; q0.push_back(8'h00);
        rd_1 = 1; addr_1 = 4'd7; q1.push_back(8'h00);
        tick();
        rd_0 = 1; addr_0 = 4'd0; q0.push_back(8'h00);
        rd_1 = 1; addr_1 = 4'd15; q1.push_back(8'h00);
        tick();
        idle();
        tick();
        tick();

        chk("q0_drain", q0.size(), 0);
        chk("q1_drain", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
